// File: rtl/wb_retire_queue.sv
// Writeback retire queue: DEPTH-entry in-order FIFO between MEM and the RF write port,
// with byte strobes and youngest-match forwarding. Define WB_BYPASS_EN for same-cycle retire when empty.
module wb_retire_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ms_to_ws_valid,
  output logic                     ws_allowin,
  input  logic                     ms_gr_we,
  input  logic [ADDR_W-1:0]        ms_dest,
  input  logic [DATA_W/8-1:0]      ms_wstrb,
  input  logic [DATA_W-1:0]        ms_result,
  input  logic [PC_W-1:0]          ms_pc,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W/8-1:0]      rf_wstrb,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic                     rf_ready,
  input  logic [ADDR_W-1:0]        fwd_raddr,
  output logic                     fwd_hit,
  output logic                     fwd_partial,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   ws_count,
  output logic [PC_W-1:0]          debug_wb_pc,
  output logic [DATA_W/8-1:0]      debug_wb_rf_wen,
  output logic [ADDR_W-1:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0]        debug_wb_rf_wdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Handshakes: MEM->WS transfers when ms_to_ws_valid && ws_allowin; WS->RF transfers
  // when rf_we && rf_ready. rf_we never depends on rf_ready; no-write entries retire unconditionally.

  logic [ADDR_W-1:0] dest_q   [DEPTH];
  logic [STRB_W-1:0] wstrb_q  [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic [PC_W-1:0]   pc_q     [DEPTH];
  logic              writes_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              empty, in_writes, sel_in;
  logic              pres_valid, pres_writes;
  logic [ADDR_W-1:0] pres_dest;
  logic [STRB_W-1:0] pres_wstrb;
  logic [DATA_W-1:0] pres_data;
  logic [PC_W-1:0]   pres_pc;
  logic              retire, deq, bypass, enq;

  assign empty     = (count_q == '0);
  assign in_writes = ms_gr_we && (ms_dest != '0) && (|ms_wstrb);

`ifdef WB_BYPASS_EN
  // An empty queue presents the incoming entry directly to the RF port.
  assign sel_in = empty;
`else
  assign sel_in = 1'b0;
`endif

  assign pres_valid  = sel_in ? ms_to_ws_valid : !empty;
  assign pres_writes = sel_in ? in_writes : writes_q[rd_ptr_q];
  assign pres_dest   = sel_in ? ms_dest   : dest_q[rd_ptr_q];
  assign pres_wstrb  = sel_in ? ms_wstrb  : wstrb_q[rd_ptr_q];
  assign pres_data   = sel_in ? ms_result : result_q[rd_ptr_q];
  assign pres_pc     = sel_in ? ms_pc     : pc_q[rd_ptr_q];

  assign retire = pres_valid && (!pres_writes || rf_ready);
  assign deq    = retire && !empty;
  assign bypass = retire && sel_in;

  assign ws_allowin = (count_q != CNT_W'(DEPTH));
  assign enq        = ms_to_ws_valid && ws_allowin && !bypass;

  assign rf_we    = pres_valid && pres_writes;
  assign rf_waddr = pres_dest;
  assign rf_wstrb = pres_wstrb;
  assign rf_wdata = pres_data;

  assign debug_wb_pc       = pres_pc;
  assign debug_wb_rf_wnum  = pres_dest;
  assign debug_wb_rf_wdata = pres_data;
  assign debug_wb_rf_wen   = (retire && pres_writes) ? pres_wstrb : '0;

  assign ws_count = count_q;

  assign rd_ptr_d = rd_ptr_q + PTR_W'(deq);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(enq);
  assign count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry validity is implied by count/rd_ptr, so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      dest_q[wr_ptr_q]   <= ms_dest;
      wstrb_q[wr_ptr_q]  <= ms_wstrb;
      result_q[wr_ptr_q] <= ms_result;
      pc_q[wr_ptr_q]     <= ms_pc;
      writes_q[wr_ptr_q] <= in_writes;
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  logic [PTR_W-1:0] idx;
  always_comb begin
    fwd_hit     = 1'b0;
    fwd_partial = 1'b0;
    fwd_data    = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && writes_q[idx] && (dest_q[idx] == fwd_raddr) &&
          (fwd_raddr != '0)) begin
        fwd_hit     = 1'b1;
        fwd_partial = ~&wstrb_q[idx];
        fwd_data    = result_q[idx];
      end
    end
  end

endmodule
